// File: rtl/vga_object_renderer_if.sv
// Object-write and commit handshake between game logic and the renderer.
// The master drives shadow-bank writes and commit requests; the slave reports readiness.
interface vga_object_renderer_if #(
    parameter int COORD_W = 10,
    parameter int IDX_W   = 3
);
    logic               wr_valid;
    logic               wr_ready;
    logic [IDX_W-1:0]   wr_idx;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [COORD_W-1:0] wr_w;
    logic [COORD_W-1:0] wr_h;
    logic [2:0]         wr_color;
    logic               wr_en_obj;
    logic               commit_req;
    logic               commit_pending;

    modport master (
        output wr_valid, wr_idx, wr_x, wr_y, wr_w, wr_h, wr_color, wr_en_obj, commit_req,
        input  wr_ready, commit_pending
    );
    modport slave (
        input  wr_valid, wr_idx, wr_x, wr_y, wr_w, wr_h, wr_color, wr_en_obj, commit_req,
        output wr_ready, commit_pending
    );
endinterface

// File: rtl/vga_object_renderer.sv
// Draws N_OBJ double-buffered rectangles over the raster with a fixed 2-cycle pipeline;
// the write port stalls while a commit is armed, and bird-vs-object overlap is reported per frame.
module vga_object_renderer #(
    parameter int N_OBJ   = 4,
    parameter int COORD_W = 10,
    parameter int IDX_W   = 3
) (
    input  logic               board_clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] counter_x,
    input  logic [COORD_W-1:0] counter_y,
    input  logic               in_display,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic               frame_start,
    vga_object_renderer_if.slave wr,
    output logic               vga_r,
    output logic               vga_g,
    output logic               vga_b,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               hit_any,
    output logic               collision
);
    typedef struct packed {
        logic               en;
        logic [2:0]         color;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } obj_t;

    typedef enum logic {IDLE, ARMED} cstate_t;

    obj_t             shadow_q [N_OBJ];
    obj_t             shadow_d [N_OBJ];
    obj_t             active_q [N_OBJ];
    obj_t             active_d [N_OBJ];
    cstate_t          state_q, state_d;

    logic [COORD_W:0] end_x [N_OBJ];
    logic [COORD_W:0] end_y [N_OBJ];
    logic [N_OBJ-1:0] hit;

    logic [N_OBJ-1:0] hit_s1_q, hit_s1_d;
    logic             disp_s1_q, disp_s1_d;
    logic             hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    logic [2:0]       rgb_q, rgb_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             any_q, any_d;
    logic             hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d;
    logic             acc_q, acc_d;
    logic             coll_q, coll_d;
    logic             overlap;
    logic [IDX_W-1:0] win_idx;
    logic [2:0]       win_color;

    assign wr.wr_ready       = (state_q == IDLE);
    assign wr.commit_pending = (state_q == ARMED);

    // Copy uses shadow_d so a write landing on the commit edge is included.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr.wr_valid && wr.wr_ready) begin
            for (int k = 0; k < N_OBJ; k++) begin
                if (wr.wr_idx == IDX_W'(k)) begin
                    shadow_d[k] = '{en: wr.wr_en_obj, color: wr.wr_color,
                                    x: wr.wr_x, y: wr.wr_y, w: wr.wr_w, h: wr.wr_h};
                end
            end
        end
        case (state_q)
            IDLE: begin
                if (wr.commit_req && frame_start) active_d = shadow_d;
                else if (wr.commit_req)           state_d  = ARMED;
            end
            ARMED: begin
                if (frame_start) begin
                    active_d = shadow_d;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Far edges are widened by one bit so objects near the right/bottom clip instead of wrapping.
    always_comb begin
        for (int k = 0; k < N_OBJ; k++) begin
            end_x[k] = {1'b0, active_q[k].x} + {1'b0, active_q[k].w};
            end_y[k] = {1'b0, active_q[k].y} + {1'b0, active_q[k].h};
            hit[k]   = active_q[k].en
                     && (counter_x >= active_q[k].x) && ({1'b0, counter_x} < end_x[k])
                     && (counter_y >= active_q[k].y) && ({1'b0, counter_y} < end_y[k]);
        end
    end

    always_comb begin
        hit_s1_d  = hit;
        disp_s1_d = in_display;
        hs_s1_d   = h_sync_in;
        vs_s1_d   = v_sync_in;

        win_idx   = '0;
        win_color = 3'b000;
        for (int k = N_OBJ - 1; k >= 0; k--) begin
            if (hit_s1_q[k]) begin
                win_idx   = IDX_W'(k);
                win_color = active_q[k].color;
            end
        end
        any_d   = disp_s1_q && (|hit_s1_q);
        idx_d   = any_d ? win_idx : '0;
        rgb_d   = any_d ? win_color : 3'b000;
        hs_s2_d = hs_s1_q;
        vs_s2_d = vs_s1_q;

        overlap = disp_s1_q && hit_s1_q[0] && (|hit_s1_q[N_OBJ-1:1]);
        if (frame_start) begin
            coll_d = acc_q | overlap;
            acc_d  = 1'b0;
        end else begin
            coll_d = coll_q;
            acc_d  = acc_q | overlap;
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            shadow_q  <= '{default: '0};
            active_q  <= '{default: '0};
            state_q   <= IDLE;
            hit_s1_q  <= '0;
            disp_s1_q <= 1'b0;
            hs_s1_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            rgb_q     <= 3'b000;
            idx_q     <= '0;
            any_q     <= 1'b0;
            hs_s2_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            acc_q     <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            state_q   <= state_d;
            hit_s1_q  <= hit_s1_d;
            disp_s1_q <= disp_s1_d;
            hs_s1_q   <= hs_s1_d;
            vs_s1_q   <= vs_s1_d;
            rgb_q     <= rgb_d;
            idx_q     <= idx_d;
            any_q     <= any_d;
            hs_s2_q   <= hs_s2_d;
            vs_s2_q   <= vs_s2_d;
            acc_q     <= acc_d;
            coll_q    <= coll_d;
        end
    end

    assign vga_r      = rgb_q[2];
    assign vga_g      = rgb_q[1];
    assign vga_b      = rgb_q[0];
    assign hit_idx    = idx_q;
    assign hit_any    = any_q;
    assign h_sync_out = hs_s2_q;
    assign v_sync_out = vs_s2_q;
    assign collision  = coll_q;
endmodule

// File: tb/tb_vga_object_renderer.sv
// Bench for vga_object_renderer: directed scenarios plus a randomized pixel stream
// compared against a rectangle-list reference model.
module tb_vga_object_renderer;
    localparam int N_OBJ   = 4;
    localparam int COORD_W = 10;
    localparam int IDX_W   = 3;

    logic               board_clk = 1'b0;
    logic               Reset = 1'b1;
    logic [COORD_W-1:0] counter_x = '0;
    logic [COORD_W-1:0] counter_y = '0;
    logic               in_display = 1'b0;
    logic               h_sync_in = 1'b0;
    logic               v_sync_in = 1'b0;
    logic               frame_start = 1'b0;
    logic               vga_r, vga_g, vga_b, h_sync_out, v_sync_out, hit_any, collision;
    logic [IDX_W-1:0]   hit_idx;

    vga_object_renderer_if #(.COORD_W(COORD_W), .IDX_W(IDX_W)) wif ();

    vga_object_renderer #(.N_OBJ(N_OBJ), .COORD_W(COORD_W), .IDX_W(IDX_W)) dut (
        .board_clk  (board_clk),
        .Reset      (Reset),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .in_display (in_display),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .frame_start(frame_start),
        .wr         (wif),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .hit_idx    (hit_idx),
        .hit_any    (hit_any),
        .collision  (collision)
    );

    always #5 board_clk = ~board_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: shadow/active rectangle lists plus commit and collision flags.
    int sh_x[N_OBJ], sh_y[N_OBJ], sh_w[N_OBJ], sh_h[N_OBJ], sh_c[N_OBJ];
    int act_x[N_OBJ], act_y[N_OBJ], act_w[N_OBJ], act_h[N_OBJ], act_c[N_OBJ];
    bit sh_en[N_OBJ], act_en[N_OBJ];
    bit m_pending, m_acc, m_coll;

    function automatic void model_reset();
        for (int k = 0; k < N_OBJ; k++) begin
            sh_x[k] = 0; sh_y[k] = 0; sh_w[k] = 0; sh_h[k] = 0; sh_c[k] = 0; sh_en[k] = 0;
            act_x[k] = 0; act_y[k] = 0; act_w[k] = 0; act_h[k] = 0; act_c[k] = 0; act_en[k] = 0;
        end
        m_pending = 0; m_acc = 0; m_coll = 0;
    endfunction

    function automatic bit obj_hit(int k, int cx, int cy);
        return act_en[k] && cx >= act_x[k] && cx < act_x[k] + act_w[k]
                         && cy >= act_y[k] && cy < act_y[k] + act_h[k];
    endfunction

    // {hit_any, hit_idx[2:0], r, g, b}
    function automatic logic [6:0] ref_pixel(int cx, int cy, bit disp);
        if (disp)
            for (int k = 0; k < N_OBJ; k++)
                if (obj_hit(k, cx, cy)) return {1'b1, 3'(k), 3'(act_c[k])};
        return 7'b0;
    endfunction

    function automatic logic [6:0] dut_pixel();
        return {hit_any, hit_idx, vga_r, vga_g, vga_b};
    endfunction

    task automatic tick();
        bit ov;
        bit other;
        int idx;
        other = 0;
        for (int k = 1; k < N_OBJ; k++) other |= obj_hit(k, int'(counter_x), int'(counter_y));
        ov  = in_display && obj_hit(0, int'(counter_x), int'(counter_y)) && other;
        idx = int'(wif.wr_idx);
        if (wif.wr_valid && !m_pending && idx < N_OBJ) begin
            sh_x[idx] = int'(wif.wr_x); sh_y[idx] = int'(wif.wr_y);
            sh_w[idx] = int'(wif.wr_w); sh_h[idx] = int'(wif.wr_h);
            sh_c[idx] = int'(wif.wr_color); sh_en[idx] = wif.wr_en_obj;
        end
        if (frame_start) begin
            if (m_pending || wif.commit_req) begin
                act_x = sh_x; act_y = sh_y; act_w = sh_w; act_h = sh_h; act_c = sh_c; act_en = sh_en;
            end
            m_pending = 0;
            m_coll    = m_acc | ov;
            m_acc     = 0;
        end else begin
            if (wif.commit_req) m_pending = 1;
            m_acc |= ov;
        end
        @(posedge board_clk);
        #1;
    endtask

    task automatic set_pix(int x, int y, bit disp);
        counter_x  = COORD_W'(x);
        counter_y  = COORD_W'(y);
        in_display = disp;
    endtask

    task automatic write_obj(int idx, int x, int y, int w, int h, int c, bit en);
        wif.wr_idx   = IDX_W'(idx);
        wif.wr_x     = COORD_W'(x);
        wif.wr_y     = COORD_W'(y);
        wif.wr_w     = COORD_W'(w);
        wif.wr_h     = COORD_W'(h);
        wif.wr_color = 3'(c);
        wif.wr_en_obj = en;
        wif.wr_valid = 1'b1;
        tick();
        wif.wr_valid = 1'b0;
    endtask

    task automatic commit_now();
        in_display = 1'b0;
        wif.commit_req = 1'b1;
        frame_start = 1'b1;
        tick();
        wif.commit_req = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic frame_pulse();
        in_display = 1'b0;
        tick(); tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        h_sync_in = 1'b1; v_sync_in = 1'b1;
        repeat (3) @(posedge board_clk);
        #1;
        checks++;
        if ({dut_pixel(), h_sync_out, v_sync_out, collision, wif.commit_pending, wif.wr_ready} !== 12'b1)
            begin errors++; $display("FAIL reset_init: got %b want %b",
                {dut_pixel(), h_sync_out, v_sync_out, collision, wif.commit_pending, wif.wr_ready}, 12'b1); end
        Reset = 1'b0;
        model_reset();
        write_obj(0, 10, 10, 20, 20, 7, 1);
        commit_now();
        set_pix(15, 15, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_000_111) begin errors++; $display("FAIL reset_pre_draw: got %b want %b", dut_pixel(), 7'b1_000_111); end
        wif.commit_req = 1'b1; tick(); wif.commit_req = 1'b0;
        checks++;
        if (wif.commit_pending !== 1'b1) begin errors++; $display("FAIL reset_armed: got %b want 1", wif.commit_pending); end
        Reset = 1'b1;
        #2;
        checks++;
        if ({dut_pixel(), h_sync_out, v_sync_out, collision, wif.commit_pending, wif.wr_ready} !== 12'b1)
            begin errors++; $display("FAIL reset_mid: got %b want %b",
                {dut_pixel(), h_sync_out, v_sync_out, collision, wif.commit_pending, wif.wr_ready}, 12'b1); end
        model_reset();
        tick();
        Reset = 1'b0;
        h_sync_in = 1'b0; v_sync_in = 1'b0;
        tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b0) begin errors++; $display("FAIL reset_post_draw: got %b want 0", dut_pixel()); end
    endtask

    task automatic test_commit_basic();
        write_obj(1, 100, 50, 80, 100, 2, 1);
        wif.commit_req = 1'b1; tick(); wif.commit_req = 1'b0;
        checks++;
        if (wif.wr_ready !== 1'b0) begin errors++; $display("FAIL armed_ready: got %b want 0", wif.wr_ready); end
        set_pix(120, 60, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b0) begin errors++; $display("FAIL before_commit: got %b want 0", dut_pixel()); end
        frame_pulse();
        set_pix(120, 60, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_001_010) begin errors++; $display("FAIL obj1_inside: got %b want %b", dut_pixel(), 7'b1_001_010); end
        set_pix(179, 149, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_001_010) begin errors++; $display("FAIL obj1_corner: got %b want %b", dut_pixel(), 7'b1_001_010); end
        set_pix(180, 60, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b0) begin errors++; $display("FAIL obj1_right_edge: got %b want 0", dut_pixel()); end
        set_pix(120, 150, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b0) begin errors++; $display("FAIL obj1_bottom_edge: got %b want 0", dut_pixel()); end
        set_pix(120, 60, 0); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b0) begin errors++; $display("FAIL blanked: got %b want 0", dut_pixel()); end
    endtask

    task automatic test_collision();
        write_obj(0, 200, 200, 20, 20, 4, 1);
        write_obj(1, 190, 190, 40, 40, 2, 1);
        commit_now();
        set_pix(205, 205, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_000_100) begin errors++; $display("FAIL priority: got %b want %b", dut_pixel(), 7'b1_000_100); end
        set_pix(195, 195, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_001_010) begin errors++; $display("FAIL obj1_only: got %b want %b", dut_pixel(), 7'b1_001_010); end
        frame_pulse();
        checks++;
        if (collision !== 1'b1) begin errors++; $display("FAIL coll_set: got %b want 1", collision); end
        set_pix(205, 205, 1); tick();
        write_obj(0, 500, 400, 20, 20, 4, 1);
        wif.commit_req = 1'b1; tick(); wif.commit_req = 1'b0;
        frame_pulse();
        checks++;
        if (collision !== 1'b1) begin errors++; $display("FAIL coll_hold: got %b want 1", collision); end
        set_pix(505, 405, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_000_100) begin errors++; $display("FAIL obj0_moved: got %b want %b", dut_pixel(), 7'b1_000_100); end
        set_pix(205, 205, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_001_010) begin errors++; $display("FAIL obj1_uncovered: got %b want %b", dut_pixel(), 7'b1_001_010); end
        frame_pulse();
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b want 0", collision); end
    endtask

    task automatic test_no_wrap();
        int x;
        write_obj(2, 1000, 10, 100, 10, 3, 1);
        write_obj(3, 300, 300, 0, 10, 7, 1);
        write_obj(5, 0, 10, 60, 10, 7, 1);
        commit_now();
        for (int i = 0; i < 4; i++) begin
            x = (i == 0) ? 0 : (i == 1) ? 99 : $urandom_range(1, 98);
            set_pix(x, 12, 1); tick(); tick();
            checks++;
            if (dut_pixel() !== 7'b0) begin errors++; $display("FAIL no_wrap_x%0d: got %b want 0", x, dut_pixel()); end
        end
        set_pix(1000, 12, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_010_011) begin errors++; $display("FAIL far_left_edge: got %b want %b", dut_pixel(), 7'b1_010_011); end
        set_pix(1023, 19, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_010_011) begin errors++; $display("FAIL clipped_edge: got %b want %b", dut_pixel(), 7'b1_010_011); end
        set_pix(300, 302, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b0) begin errors++; $display("FAIL zero_width: got %b want 0", dut_pixel()); end
    endtask

    task automatic test_same_cycle_commit();
        wif.wr_idx = 3'd3; wif.wr_x = 10'd300; wif.wr_y = 10'd300; wif.wr_w = 10'd10; wif.wr_h = 10'd10;
        wif.wr_color = 3'b001; wif.wr_en_obj = 1'b1; wif.wr_valid = 1'b1;
        wif.commit_req = 1'b1; frame_start = 1'b1;
        tick();
        wif.wr_valid = 1'b0; wif.commit_req = 1'b0; frame_start = 1'b0;
        checks++;
        if (wif.commit_pending !== 1'b0) begin errors++; $display("FAIL same_cycle_pending: got %b want 0", wif.commit_pending); end
        set_pix(305, 305, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_011_001) begin errors++; $display("FAIL same_cycle_draw: got %b want %b", dut_pixel(), 7'b1_011_001); end
        wif.commit_req = 1'b1; tick(); wif.commit_req = 1'b0;
        wif.wr_color = 3'b110; wif.wr_valid = 1'b1;
        tick();
        wif.commit_req = 1'b1; tick(); wif.commit_req = 1'b0;
        checks++;
        if ({wif.wr_ready, wif.commit_pending} !== 2'b01) begin errors++; $display("FAIL stalled: got %b want 01", {wif.wr_ready, wif.commit_pending}); end
        frame_pulse();
        checks++;
        if ({wif.wr_ready, wif.commit_pending} !== 2'b10) begin errors++; $display("FAIL after_commit: got %b want 10", {wif.wr_ready, wif.commit_pending}); end
        tick();
        wif.wr_valid = 1'b0;
        set_pix(305, 305, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_011_001) begin errors++; $display("FAIL stalled_write_hidden: got %b want %b", dut_pixel(), 7'b1_011_001); end
        frame_pulse();
        set_pix(305, 305, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_011_001) begin errors++; $display("FAIL single_copy: got %b want %b", dut_pixel(), 7'b1_011_001); end
        commit_now();
        set_pix(305, 305, 1); tick(); tick();
        checks++;
        if (dut_pixel() !== 7'b1_011_110) begin errors++; $display("FAIL stalled_write_landed: got %b want %b", dut_pixel(), 7'b1_011_110); end
    endtask

    // Random stream: every cycle a new pixel and sync pair; outputs must trail by exactly two cycles.
    task automatic test_back_to_back();
        logic [8:0] q[$];
        logic [8:0] exp_v, got_v;
        for (int k = 0; k < N_OBJ; k++)
            write_obj(k, $urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 40),
                      $urandom_range(0, 40), $urandom_range(0, 7), ($urandom_range(0, 4) != 0));
        commit_now();
        for (int n = 0; n < 200; n++) begin
            set_pix($urandom_range(0, 99), $urandom_range(0, 99), ($urandom_range(0, 3) != 0));
            h_sync_in = 1'($urandom);
            v_sync_in = 1'($urandom);
            q.push_back({h_sync_in, v_sync_in, ref_pixel(int'(counter_x), int'(counter_y), in_display)});
            tick();
            if (q.size() == 2) begin
                exp_v = q.pop_front();
                got_v = {h_sync_out, v_sync_out, dut_pixel()};
                checks++;
                if (got_v !== exp_v) begin errors++; $display("FAIL stream_%0d: got %b want %b", n, got_v, exp_v); end
            end
        end
        h_sync_in = 1'b0; v_sync_in = 1'b0;
        frame_pulse();
        checks++;
        if (collision !== m_coll) begin errors++; $display("FAIL stream_collision: got %b want %b", collision, m_coll); end
        checks++;
        if (wif.wr_ready !== !m_pending) begin errors++; $display("FAIL stream_ready: got %b want %b", wif.wr_ready, !m_pending); end
    endtask

    initial begin
        wif.wr_valid = 1'b0; wif.wr_idx = '0; wif.wr_x = '0; wif.wr_y = '0; wif.wr_w = '0; wif.wr_h = '0;
        wif.wr_color = 3'b000; wif.wr_en_obj = 1'b0; wif.commit_req = 1'b0;
        model_reset();
        test_reset();
        test_commit_basic();
        test_collision();
        test_no_wrap();
        test_same_cycle_commit();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
